// File: rtl/mmu_paged_pkg.sv
// Shared definitions for the paged MMU: register offsets, switch FSM states, CTRL bit positions.
// Optional write protection is selected with MMU_WRPROT_EN in mmu_paged.
package mmu_paged_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_SEL    = 4'h1;
  localparam logic [3:0] REG_SWITCH = 4'h2;
  localparam logic [3:0] REG_PAGE   = 4'h8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ACT_LSB = 1;
  localparam int CTRL_ARMED   = 6;
  localparam int CTRL_WPF     = 7;

  typedef enum logic {
    SW_IDLE  = 1'b0,
    SW_ARMED = 1'b1
  } sw_state_t;

  // Page registers live at +8..+8+npage-1 of the window.
  function automatic logic is_page_off(input logic [3:0] off, input int npage);
    return (off[3] == REG_PAGE[3]) && (int'(off[2:0]) < npage);
  endfunction

endpackage

// File: rtl/mmu_task_switch.sv
// Deferred task switch: SWITCH write arms a countdown of bus cycles, expiry loads ACTIVE.
// Latency SWITCH_DELAY end-of-cycle events; vector fetch cancels; no backpressure.
module mmu_task_switch
  import mmu_paged_pkg::*;
#(
  parameter int TASK_BITS    = 2,
  parameter int SWITCH_DELAY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 eoc,
  input  logic                 vec,
  input  logic                 sw_wr,
  input  logic [TASK_BITS-1:0] sw_dat,
  output logic [TASK_BITS-1:0] active,
  output logic [TASK_BITS-1:0] pending,
  output logic                 armed
);

  sw_state_t            state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [TASK_BITS-1:0] pending_nxt, active_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SW_IDLE;
      cnt     <= '0;
      pending <= '0;
      active  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      active  <= active_nxt;
    end
  end

  // Vector fetch outranks both a new SWITCH write and a same-cycle expiry.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    active_nxt  = active;
    if (eoc) begin
      if (vec) begin
        active_nxt = '0;
        state_nxt  = SW_IDLE;
        cnt_nxt    = '0;
      end else if (sw_wr) begin
        pending_nxt = sw_dat;
        cnt_nxt     = 4'(SWITCH_DELAY);
        state_nxt   = SW_ARMED;
      end else if (state == SW_ARMED) begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          active_nxt = pending;
          state_nxt  = SW_IDLE;
        end
      end
    end
  end

  assign armed = (state == SW_ARMED);

endmodule

// File: rtl/mmu_paged.sv
// Paged MMU for a 16-bit CPU bus: per-task page tables, register window, deferred task switch.
// PA is combinational from ADDR; register writes commit at end of bus cycle; MMU_WRPROT_EN adds write protect.
module mmu_paged
  import mmu_paged_pkg::*;
#(
  parameter int          TASK_BITS    = 2,
  parameter int          PAGE_BITS    = 13,
  parameter int          PHYS_W       = 20,
  parameter logic [15:0] MMU_BASE     = 16'hFE10,
  parameter int          SWITCH_DELAY = 3
) (
  input  logic                          CLKX4,
  input  logic                          nRESET,
  input  logic                          E,
  input  logic [15:0]                   ADDR,
  input  logic                          RnW,
  input  logic                          BA,
  input  logic                          BS,
  input  logic [7:0]                    DATA_in,
  output logic [7:0]                    DATA_out,
  output logic                          DATA_oe,
  output logic [PHYS_W-PAGE_BITS-1:0]   PA,
  output logic                          nWR,
  output logic                          WPFAULT
);

  localparam int NTASK = 1 << TASK_BITS;
  localparam int PG_W  = 16 - PAGE_BITS;
  localparam int NPAGE = 1 << PG_W;
  localparam int PFN_W = PHYS_W - PAGE_BITS;

  logic                 e_d, eoc;
  logic [7:0]           dhold;
  logic [15:0]          ahold;
  logic                 rhold;
  logic                 en;
  logic [TASK_BITS-1:0] sel, active, pending, eff;
  logic                 armed, vec, wpf, wp_rd;
  logic [PFN_W-1:0]     pfn [NTASK][NPAGE];
  logic [PG_W-1:0]      pg, r_idx, w_idx;
  logic [3:0]           r_off, w_off;
  logic                 r_win, w_win, wr_commit, wr_page, ctrl_rd;

  assign eoc   = e_d & ~E;
  assign vec   = BS & ~BA;
  assign eff   = vec ? '0 : active;
  assign pg    = ADDR[15:PAGE_BITS];
  assign r_win = (ADDR[15:4] == MMU_BASE[15:4]);
  assign w_win = (ahold[15:4] == MMU_BASE[15:4]);
  assign r_off = ADDR[3:0];
  assign w_off = ahold[3:0];
  assign r_idx = r_off[PG_W-1:0];
  assign w_idx = w_off[PG_W-1:0];

  // Register writes use the address/data held from the E-high phase.
  assign wr_commit = eoc & ~rhold & w_win;
  assign wr_page   = wr_commit & is_page_off(w_off, NPAGE);
  assign ctrl_rd   = eoc & rhold & w_win & (w_off == REG_CTRL);

  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      e_d   <= 1'b0;
      dhold <= '0;
      ahold <= '0;
      rhold <= 1'b0;
      en    <= 1'b0;
      sel   <= '0;
    end else begin
      e_d <= E;
      if (E) begin
        dhold <= DATA_in;
        ahold <= ADDR;
        rhold <= RnW;
      end
      if (wr_commit && (w_off == REG_CTRL)) en  <= dhold[CTRL_EN];
      if (wr_commit && (w_off == REG_SEL))  sel <= dhold[TASK_BITS-1:0];
    end
  end

  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      for (int t = 0; t < NTASK; t++)
        for (int i = 0; i < NPAGE; i++)
          pfn[t][i] <= PFN_W'(i);
    end else if (wr_page) begin
      pfn[sel][w_idx] <= dhold[PFN_W-1:0];
    end
  end

`ifdef MMU_WRPROT_EN
  logic [NPAGE-1:0] wp [NTASK];
  logic             wp_blk, wp_hold;

  assign wp_blk = E & ~RnW & en & wp[eff][pg];
  assign nWR    = ~(E & ~RnW) | wp_blk;
  assign wp_rd  = wp[sel][r_idx];

  always_ff @(posedge CLKX4 or negedge nRESET) begin
    if (!nRESET) begin
      for (int t = 0; t < NTASK; t++) wp[t] <= '0;
      wp_hold <= 1'b0;
      wpf     <= 1'b0;
    end else begin
      if (wr_page) wp[sel][w_idx] <= dhold[7];
      if (E) wp_hold <= wp_blk;
      // A fault landing on the same edge as a CTRL read must survive it.
      if (eoc && wp_hold) wpf <= 1'b1;
      else if (ctrl_rd)   wpf <= 1'b0;
    end
  end
`else
  assign nWR   = ~(E & ~RnW);
  assign wp_rd = 1'b0;
  assign wpf   = 1'b0;
`endif

  assign WPFAULT = wpf;
  assign PA      = en ? pfn[eff][pg] : PFN_W'(pg);

  mmu_task_switch #(
    .TASK_BITS    (TASK_BITS),
    .SWITCH_DELAY (SWITCH_DELAY)
  ) u_switch (
    .clk     (CLKX4),
    .rst_n   (nRESET),
    .eoc     (eoc),
    .vec     (vec),
    .sw_wr   (wr_commit && (w_off == REG_SWITCH)),
    .sw_dat  (dhold[TASK_BITS-1:0]),
    .active  (active),
    .pending (pending),
    .armed   (armed)
  );

  assign DATA_oe = E & RnW & r_win &
                   ((r_off == REG_CTRL) || (r_off == REG_SEL) ||
                    (r_off == REG_SWITCH) || is_page_off(r_off, NPAGE));

  always_comb begin
    DATA_out = '0;
    if (r_win) begin
      case (r_off)
        REG_CTRL: begin
          DATA_out[CTRL_WPF]           = wpf;
          DATA_out[CTRL_ARMED]         = armed;
          DATA_out[CTRL_ACT_LSB +: 3]  = 3'(active);
          DATA_out[CTRL_EN]            = en;
        end
        REG_SEL:    DATA_out = 8'(sel);
        REG_SWITCH: DATA_out = 8'(pending);
        default: begin
          if (is_page_off(r_off, NPAGE)) DATA_out = {wp_rd, 7'(pfn[sel][r_idx])};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_paged.sv
// Bench for mmu_paged: directed scenarios plus random bus cycles against a cycle-level reference model.
// Write-protect expectations follow MMU_WRPROT_EN when the bench is built with it.
module tb_mmu_paged;

  localparam logic [15:0] BASE = 16'hFE10;
  localparam int          DLY  = 3;

  logic        CLKX4 = 1'b0;
  logic        nRESET = 1'b0;
  logic        E = 1'b0;
  logic [15:0] ADDR = '0;
  logic        RnW = 1'b1;
  logic        BA = 1'b0;
  logic        BS = 1'b0;
  logic [7:0]  DATA_in = '0;
  logic [7:0]  DATA_out;
  logic        DATA_oe;
  logic [6:0]  PA;
  logic        nWR;
  logic        WPFAULT;

  int total = 0;
  int bad   = 0;

  mmu_paged dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .E(E), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS),
    .DATA_in(DATA_in), .DATA_out(DATA_out), .DATA_oe(DATA_oe), .PA(PA), .nWR(nWR),
    .WPFAULT(WPFAULT)
  );

  always #5 CLKX4 = ~CLKX4;

  // Reference state: what the programmer sees, updated once per completed bus cycle.
  logic       m_en, m_wpf, m_armed;
  int         m_sel, m_active, m_pending, m_left;
  logic [6:0] m_pfn [4][8];
  logic       m_wp  [4][8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 0; m_wpf = 0; m_armed = 0;
    m_sel = 0; m_active = 0; m_pending = 0; m_left = 0;
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 8; i++) begin
        m_pfn[t][i] = 7'(i);
        m_wp[t][i]  = 1'b0;
      end
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    repeat (2) @(negedge CLKX4);
    nRESET = 1'b1;
    m_reset();
  endtask

  task automatic bus(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                     input logic vec, output logic [7:0] rd, output logic [6:0] pa_o);
    logic [3:0] off;
    logic [7:0] d_exp;
    logic [6:0] pa_exp;
    logic       in_win, oe_exp, blk;
    int         eff, pg;
    @(negedge CLKX4);
    ADDR = a; RnW = rnw; DATA_in = d;
    if (vec) begin
      BS = 1'b1; BA = 1'b0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin BS = 1'b0; BA = 1'b0; end
        1:       begin BS = 1'b0; BA = 1'b1; end
        default: begin BS = 1'b1; BA = 1'b1; end
      endcase
    end
    E = 1'b1;
    repeat (2) @(negedge CLKX4);
    off    = a[3:0];
    in_win = (a[15:4] == BASE[15:4]);
    eff    = vec ? 0 : m_active;
    pg     = int'(a[15:13]);
    pa_exp = m_en ? m_pfn[eff][pg] : 7'(pg);
    oe_exp = rnw && in_win && (off <= 4'd2 || off >= 4'd8);
    d_exp  = 8'h00;
    if (off == 4'd0) d_exp = {m_wpf, m_armed, 2'b00, 3'(m_active), m_en};
    else if (off == 4'd1) d_exp = 8'(m_sel);
    else if (off >= 4'd8) d_exp = {m_wp[m_sel][off-8], m_pfn[m_sel][off-8]};
    blk = 1'b0;
`ifdef MMU_WRPROT_EN
    blk = !rnw && m_en && m_wp[eff][pg];
`endif
    chk("pa", 32'(PA), 32'(pa_exp));
    chk("oe", 32'(DATA_oe), 32'(oe_exp));
    if (oe_exp && off != 4'd2) chk("rdata", 32'(DATA_out), 32'(d_exp));
    chk("nwr", 32'(nWR), 32'(!(!rnw && !blk)));
    rd   = DATA_out;
    pa_o = PA;
    E = 1'b0;
    @(negedge CLKX4);
    if (blk) m_wpf = 1'b1;
    else if (rnw && in_win && off == 4'd0) m_wpf = 1'b0;
    if (vec) begin
      m_active = 0; m_armed = 0;
    end else if (!rnw && in_win && off == 4'd2) begin
      m_pending = int'(d[1:0]); m_left = DLY; m_armed = 1'b1;
    end else if (m_armed) begin
      m_left--;
      if (m_left == 0) begin m_active = m_pending; m_armed = 1'b0; end
    end
    if (!rnw && in_win) begin
      if (off == 4'd0) m_en = d[0];
      if (off == 4'd1) m_sel = int'(d[1:0]);
      if (off >= 4'd8) begin
        m_pfn[m_sel][off-8] = d[6:0];
`ifdef MMU_WRPROT_EN
        m_wp[m_sel][off-8] = d[7];
`endif
      end
    end
    chk("wpfault", 32'(WPFAULT), 32'(m_wpf));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rd;
    logic [6:0]  pa;
    logic [15:0] ra;
    m_reset();
    do_reset();

    bus(16'hA000, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("reset_pa", 32'(pa), 32'h5);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("reset_ctrl", 32'(rd), 32'h00);
    bus(16'hA000, 1'b0, 8'h11, 1'b0, rd, pa);

    bus(BASE + 16'h1, 1'b0, 8'h01, 1'b0, rd, pa);
    bus(BASE + 16'hD, 1'b0, 8'h2A, 1'b0, rd, pa);
    bus(BASE,         1'b0, 8'h01, 1'b0, rd, pa);
    bus(BASE + 16'h2, 1'b0, 8'h01, 1'b0, rd, pa);
    repeat (3) bus(16'h0000, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(16'hA000, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("switch_pa", 32'(pa), 32'h2A);

    bus(BASE + 16'h2, 1'b0, 8'h02, 1'b0, rd, pa);
    bus(16'h0000, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(16'h0000, 1'b1, 8'h00, 1'b1, rd, pa);
    repeat (4) bus(16'h2000, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("vec_cancel_ctrl", 32'(rd), 32'h01);

    bus(BASE + 16'h2, 1'b0, 8'h02, 1'b0, rd, pa);
    bus(BASE + 16'h2, 1'b0, 8'h03, 1'b0, rd, pa);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("relaunch_armed", 32'(rd), 32'h41);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("relaunch_ctrl", 32'(rd), 32'h07);

`ifdef MMU_WRPROT_EN
    do_reset();
    bus(BASE + 16'hA, 1'b0, 8'h82, 1'b0, rd, pa);
    bus(BASE,         1'b0, 8'h01, 1'b0, rd, pa);
    bus(16'h4000,     1'b0, 8'h55, 1'b0, rd, pa);
    chk("wp_fault_set", 32'(WPFAULT), 32'h1);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("wp_ctrl", 32'(rd), 32'h81);
    chk("wp_fault_clr", 32'(WPFAULT), 32'h0);
`endif

    bus(BASE + 16'h1, 1'b0, 8'h00, 1'b0, rd, pa);
    bus(BASE + 16'h9, 1'b0, 8'h33, 1'b0, rd, pa);
    bus(BASE,         1'b0, 8'h01, 1'b0, rd, pa);
    bus(BASE + 16'h2, 1'b0, 8'h02, 1'b0, rd, pa);
    @(negedge CLKX4);
    ADDR = BASE; RnW = 1'b1; BS = 1'b0; BA = 1'b0; E = 1'b1;
    @(negedge CLKX4);
    #2 nRESET = 1'b0;
    #1;
    chk("midreset_ctrl", 32'(DATA_out), 32'h00);
    chk("midreset_pa", 32'(PA), 32'h7);
    @(negedge CLKX4);
    E = 1'b0;
    @(negedge CLKX4);
    nRESET = 1'b1;
    m_reset();
    repeat (4) bus(16'h6000, 1'b1, 8'h00, 1'b0, rd, pa);
    bus(BASE, 1'b1, 8'h00, 1'b0, rd, pa);
    chk("postreset_ctrl", 32'(rd), 32'h00);
    for (int i = 0; i < 8; i++) bus(BASE + 16'(8 + i), 1'b1, 8'h00, 1'b0, rd, pa);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 0) ra = BASE + 16'($urandom_range(0, 15));
      else ra = 16'($urandom);
      bus(ra, 1'($urandom), 8'($urandom), ($urandom_range(0, 11) == 0), rd, pa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
